// File: rtl/rs_dec_stream_ctrl.sv
// Stream-side controller for the RS(204,188) decoder: paces upstream bytes into
// single-cycle CE strobes, limits blocks in flight and frames the decoded output.
module rs_dec_stream_ctrl #(
  parameter int CE_PERIOD    = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       dec_ce,
  output logic [7:0] dec_byte,
  input  logic [7:0] dec_out_byte,
  input  logic       dec_ceo,
  input  logic       dec_valid_out,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_sop,
  output logic       m_eop,
  output logic [3:0] inflight,
  output logic       frame_err,
  output logic       out_err
);

  localparam int               GAP_W      = $clog2(CE_PERIOD);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CE_PERIOD - 1);
  localparam logic [7:0]       IN_LAST    = 8'd203;
  localparam logic [7:0]       OUT_LAST   = 8'd187;
  localparam logic [3:0]       INF_LIMIT  = 4'(MAX_INFLIGHT);

  logic             r_run;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_in_cnt;
  logic [7:0]       r_out_cnt;
  logic [3:0]       r_inflight;
  logic             r_dec_ce;
  logic [7:0]       r_dec_byte;
  logic             r_m_valid;
  logic [7:0]       r_m_data;
  logic             r_m_sop;
  logic             r_m_eop;
  logic             r_frame_err;
  logic             r_out_err;

  logic w_ready;
  logic w_accept;
  logic w_in_at_last;
  logic w_blk_in;
  logic w_strobe;
  logic w_blk_out;
  logic w_frame_bad;

  // The in-flight limit only gates the first byte of a block, never mid-block.
  assign w_ready      = r_run && (r_gap_cnt == '0) &&
                        !((r_in_cnt == 8'd0) && (r_inflight >= INF_LIMIT));
  assign w_accept     = s_valid && w_ready;
  assign w_in_at_last = (r_in_cnt == IN_LAST);
  assign w_blk_in     = w_accept && w_in_at_last;
  assign w_strobe     = dec_ceo && dec_valid_out;
  assign w_blk_out    = w_strobe && (r_out_cnt == OUT_LAST);
  assign w_frame_bad  = w_accept && (s_last != w_in_at_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt  <= '0;
      r_in_cnt   <= 8'd0;
      r_dec_ce   <= 1'b0;
      r_dec_byte <= 8'd0;
    end else begin
      r_dec_ce <= w_accept;
      if (w_accept) begin
        r_dec_byte <= s_data;
        r_gap_cnt  <= GAP_RELOAD;
        r_in_cnt   <= w_in_at_last ? 8'd0 : r_in_cnt + 8'd1;
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // in_cnt free-runs on accepted bytes; s_last only feeds the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_cnt <= 8'd0;
      r_m_valid <= 1'b0;
      r_m_data  <= 8'd0;
      r_m_sop   <= 1'b0;
      r_m_eop   <= 1'b0;
    end else begin
      r_m_valid <= w_strobe;
      r_m_sop   <= w_strobe && (r_out_cnt == 8'd0);
      r_m_eop   <= w_blk_out;
      if (w_strobe) begin
        r_m_data  <= dec_out_byte;
        r_out_cnt <= (r_out_cnt == OUT_LAST) ? 8'd0 : r_out_cnt + 8'd1;
      end
    end
  end

  // Coincident block-in and block-out cancel; a block-out with nothing in flight
  // is a decoder/controller disagreement and is latched as out_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 4'd0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_blk_in && !w_blk_out) begin
        r_inflight <= r_inflight + 4'd1;
      end else if (w_blk_out && !w_blk_in) begin
        if (r_inflight == 4'd0) begin
          r_out_err <= 1'b1;
        end else begin
          r_inflight <= r_inflight - 4'd1;
        end
      end
    end
  end

  assign s_ready   = w_ready;
  assign dec_ce    = r_dec_ce;
  assign dec_byte  = r_dec_byte;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_sop     = r_m_sop;
  assign m_eop     = r_m_eop;
  assign inflight  = r_inflight;
  assign frame_err = r_frame_err;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_rs_dec_stream_ctrl.sv
// Scoreboard bench for rs_dec_stream_ctrl: one instance with the default in-flight
// limit and one with MAX_INFLIGHT=1, selected in turn onto shared stimulus.
module tb_rs_dec_stream_ctrl;

  localparam int CE_PERIOD = 8;
  localparam int CLK_NS    = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_last = 1'b0;
  logic [7:0] dec_out_byte = 8'd0;
  logic       dec_ceo = 1'b0;
  logic       dec_valid_out = 1'b0;

  logic       a_s_ready, a_dec_ce, a_m_valid, a_m_sop, a_m_eop, a_frame_err, a_out_err;
  logic [7:0] a_dec_byte, a_m_data;
  logic [3:0] a_inflight;
  logic       b_s_ready, b_dec_ce, b_m_valid, b_m_sop, b_m_eop, b_frame_err, b_out_err;
  logic [7:0] b_dec_byte, b_m_data;
  logic [3:0] b_inflight;

  logic       mx_s_ready, mx_dec_ce, mx_m_valid, mx_m_sop, mx_m_eop, mx_frame_err, mx_out_err;
  logic [7:0] mx_dec_byte, mx_m_data;
  logic [3:0] mx_inflight;

  always #(CLK_NS/2) clk = ~clk;

  rs_dec_stream_ctrl #(.CE_PERIOD(CE_PERIOD), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid & ~sel), .s_data(s_data), .s_last(s_last), .s_ready(a_s_ready),
    .dec_ce(a_dec_ce), .dec_byte(a_dec_byte),
    .dec_out_byte(dec_out_byte), .dec_ceo(dec_ceo & ~sel), .dec_valid_out(dec_valid_out),
    .m_valid(a_m_valid), .m_data(a_m_data), .m_sop(a_m_sop), .m_eop(a_m_eop),
    .inflight(a_inflight), .frame_err(a_frame_err), .out_err(a_out_err)
  );

  rs_dec_stream_ctrl #(.CE_PERIOD(CE_PERIOD), .MAX_INFLIGHT(1)) dut_bp (
    .clk(clk), .reset(reset),
    .s_valid(s_valid & sel), .s_data(s_data), .s_last(s_last), .s_ready(b_s_ready),
    .dec_ce(b_dec_ce), .dec_byte(b_dec_byte),
    .dec_out_byte(dec_out_byte), .dec_ceo(dec_ceo & sel), .dec_valid_out(dec_valid_out),
    .m_valid(b_m_valid), .m_data(b_m_data), .m_sop(b_m_sop), .m_eop(b_m_eop),
    .inflight(b_inflight), .frame_err(b_frame_err), .out_err(b_out_err)
  );

  assign mx_s_ready   = sel ? b_s_ready   : a_s_ready;
  assign mx_dec_ce    = sel ? b_dec_ce    : a_dec_ce;
  assign mx_dec_byte  = sel ? b_dec_byte  : a_dec_byte;
  assign mx_m_valid   = sel ? b_m_valid   : a_m_valid;
  assign mx_m_data    = sel ? b_m_data    : a_m_data;
  assign mx_m_sop     = sel ? b_m_sop     : a_m_sop;
  assign mx_m_eop     = sel ? b_m_eop     : a_m_eop;
  assign mx_inflight  = sel ? b_inflight  : a_inflight;
  assign mx_frame_err = sel ? b_frame_err : a_frame_err;
  assign mx_out_err   = sel ? b_out_err   : a_out_err;

  typedef struct {
    logic [7:0] data;
    longint     t;
  } ce_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    longint     t;
  } out_exp_t;

  ce_exp_t  ce_q[$];
  out_exp_t out_q[$];

  int     n_checks = 0;
  int     n_pass = 0;
  int     exp_out_cnt = 0;
  longint last_acc = 0;
  longint prev_acc = 0;
  longint t_rel = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endfunction

  // Monitor: every dec_ce / m_valid cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mx_dec_ce) begin
      chk("ce_pending", longint'(ce_q.size() > 0), 1);
      if (ce_q.size() > 0) begin
        ce_exp_t e;
        e = ce_q.pop_front();
        chk("dec_byte", mx_dec_byte, e.data);
        chk("dec_ce_time", longint'($time), e.t);
        $display("CE   byte=0x%02h t=%0t", mx_dec_byte, $time);
      end
    end
    if (mx_m_valid) begin
      chk("out_pending", longint'(out_q.size() > 0), 1);
      if (out_q.size() > 0) begin
        out_exp_t o;
        o = out_q.pop_front();
        chk("m_data", mx_m_data, o.data);
        chk("m_sop", mx_m_sop, o.sop);
        chk("m_eop", mx_m_eop, o.eop);
        chk("m_valid_time", longint'($time), o.t);
        $display("OUT  byte=0x%02h sop=%0b eop=%0b t=%0t", mx_m_data, mx_m_sop, mx_m_eop, $time);
      end
    end
  end

  initial begin
    #(CLK_NS * 60000);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(int base, int i);
    return 8'((base + i * 7) & 255);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    w = 0;
    while (!mx_s_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!mx_s_ready) begin
      chk("s_ready_wait", mx_s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    prev_acc = last_acc;
    last_acc = $time;
    ce_q.push_back('{d, longint'($time) + CLK_NS/2});
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_range(input int base, input int first, input int last_i, input int slast_at);
    for (int i = first; i <= last_i; i++) send_byte(pat(base, i), i == slast_at);
  endtask

  task automatic set_strobe(input logic [7:0] d, input logic valid);
    dec_out_byte  = d;
    dec_ceo       = 1'b1;
    dec_valid_out = valid;
    if (valid) begin
      out_q.push_back('{d, exp_out_cnt == 0, exp_out_cnt == 187, longint'($time) + CLK_NS});
      exp_out_cnt = (exp_out_cnt == 187) ? 0 : exp_out_cnt + 1;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic dec_strobe(input logic [7:0] d, input logic valid);
    set_strobe(d, valid);
    @(negedge clk);
    dec_ceo       = 1'b0;
    dec_valid_out = 1'b0;
  endtask

  task automatic out_stream(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      dec_strobe(pat(base, k), 1'b1);
      repeat (CE_PERIOD - 1) @(negedge clk);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_s_ready"}, mx_s_ready, 0);
    chk({tag, "_dec_ce"}, mx_dec_ce, 0);
    chk({tag, "_dec_byte"}, mx_dec_byte, 0);
    chk({tag, "_m_valid"}, mx_m_valid, 0);
    chk({tag, "_m_data"}, mx_m_data, 0);
    chk({tag, "_m_sop"}, mx_m_sop, 0);
    chk({tag, "_m_eop"}, mx_m_eop, 0);
    chk({tag, "_inflight"}, mx_inflight, 0);
    chk({tag, "_frame_err"}, mx_frame_err, 0);
    chk({tag, "_out_err"}, mx_out_err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared("rst");
    reset = 1'b0;
    t_rel = $time;

    // Single block: 8-clock CE spacing, last byte 0xB8, inflight 0 -> 1.
    for (int i = 0; i < 203; i++) begin
      send_byte(pat(16, i), 1'b0);
      if (i == 0) chk("first_accept_delay", last_acc - t_rel, CLK_NS + CLK_NS/2);
      else        chk("ce_spacing", last_acc - prev_acc, CE_PERIOD * CLK_NS);
    end
    chk("blk1_inflight_pre", mx_inflight, 0);
    send_byte(8'hB8, 1'b1);
    chk("ce_spacing_last", last_acc - prev_acc, CE_PERIOD * CLK_NS);
    chk("blk1_inflight_post", mx_inflight, 1);
    chk("blk1_frame_err", mx_frame_err, 0);

    // Output framing: 188 strobes, inflight 1 -> 0.
    out_stream(64, 187);
    chk("out1_inflight_pre", mx_inflight, 1);
    dec_strobe(8'hE1, 1'b1);
    chk("out1_inflight_post", mx_inflight, 0);
    chk("out1_out_err", mx_out_err, 0);
    repeat (CE_PERIOD) @(negedge clk);

    // Simultaneous block-in and block-out with inflight=2.
    send_range(32, 0, 203, 203);
    send_range(48, 0, 203, 203);
    chk("sim_inflight_two", mx_inflight, 2);
    send_range(80, 0, 202, -1);
    out_stream(96, 187);
    chk("sim_ready", mx_s_ready, 1);
    s_valid = 1'b1;
    s_data  = 8'h5C;
    s_last  = 1'b1;
    set_strobe(8'hA7, 1'b1);
    @(posedge clk);
    ce_q.push_back('{8'h5C, longint'($time) + CLK_NS/2});
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; dec_ceo = 1'b0; dec_valid_out = 1'b0;
    chk("sim_inflight_hold", mx_inflight, 2);
    repeat (CE_PERIOD) @(negedge clk);

    // Reset after 50 bytes of a block, with out_cnt mid-block.
    out_stream(112, 5);
    send_range(128, 0, 49, -1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cleared("midrst");
    reset = 1'b0;
    exp_out_cnt = 0;
    send_range(144, 0, 202, -1);
    chk("restart_inflight_pre", mx_inflight, 0);
    send_byte(8'h3D, 1'b1);
    chk("restart_inflight_post", mx_inflight, 1);
    chk("restart_frame_err", mx_frame_err, 0);
    out_stream(160, 188);
    chk("restart_out_inflight", mx_inflight, 0);

    // Framing error on byte 100; in_cnt keeps counting to 203.
    send_range(176, 0, 99, -1);
    chk("ferr_before", mx_frame_err, 0);
    send_byte(pat(176, 100), 1'b1);
    chk("ferr_set", mx_frame_err, 1);
    send_range(176, 101, 202, -1);
    chk("ferr_sticky", mx_frame_err, 1);
    chk("ferr_inflight_pre", mx_inflight, 0);
    send_byte(pat(176, 203), 1'b1);
    chk("ferr_inflight_post", mx_inflight, 1);
    chk("ferr_still", mx_frame_err, 1);

    // Output error: block-end strobe with nothing in flight; a CEO without
    // Valid_out in between must be ignored.
    out_stream(192, 188);
    chk("oerr_inflight_zero", mx_inflight, 0);
    dec_strobe(8'hFF, 1'b0);
    repeat (CE_PERIOD - 1) @(negedge clk);
    out_stream(208, 187);
    chk("oerr_before", mx_out_err, 0);
    dec_strobe(8'h99, 1'b1);
    chk("oerr_set", mx_out_err, 1);
    chk("oerr_inflight_hold", mx_inflight, 0);
    repeat (CE_PERIOD) @(negedge clk);

    // Back-pressure on the MAX_INFLIGHT=1 instance.
    sel = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_cleared("bp_rst");
    reset = 1'b0;
    exp_out_cnt = 0;
    send_range(224, 0, 203, 203);
    chk("bp_inflight_one", mx_inflight, 1);
    s_valid = 1'b1;
    s_data  = 8'h11;
    s_last  = 1'b0;
    repeat (CE_PERIOD) @(negedge clk);
    for (int k = 0; k < 187; k++) begin
      dec_strobe(pat(240, k), 1'b1);
      chk("bp_stalled", mx_s_ready, 0);
      repeat (CE_PERIOD - 1) @(negedge clk);
    end
    dec_strobe(8'h42, 1'b1);
    chk("bp_inflight_zero", mx_inflight, 0);
    chk("bp_ready_release", mx_s_ready, 1);
    @(posedge clk);
    ce_q.push_back('{8'h11, longint'($time) + CLK_NS/2});
    @(negedge clk);
    s_valid = 1'b0;

    repeat (20) @(negedge clk);
    chk("ce_queue_drained", ce_q.size(), 0);
    chk("out_queue_drained", out_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
